// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Size codes, FSM state encoding and the DMA starvation default.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_align_check.sv
// Natural-alignment check for a memory access.
// Flags half/word/double accesses whose low address bits are not zero.
module dmem_align_check
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [2:0] i_addrLow,
    output logic       o_misaligned
);

    always_comb begin
        o_misaligned = 1'b0;
        unique case (i_size)
            SIZE_BYTE:   o_misaligned = 1'b0;
            SIZE_HALF:   o_misaligned = i_addrLow[0];
            SIZE_WORD:   o_misaligned = |i_addrLow[1:0];
            SIZE_DOUBLE: o_misaligned = |i_addrLow;
            default:     o_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port (core/DMA) arbiter in front of a single-ported data memory.
// Optional misalignment rejection: define DMEM_ARB_ALIGN_CHECK_EN.
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 11,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  resetN,

    input  logic                  coreReq,
    input  logic                  coreWrite,
    input  logic [ADDR_WIDTH-1:0] coreAddress,
    input  logic [63:0]           coreWriteData,
    input  logic [1:0]            coreSize,
    input  logic                  coreSignExtended,
    output logic                  coreGrant,
    output logic                  coreValid,
    output logic [63:0]           coreReadData,
    output logic                  coreError,

    input  logic                  dmaReq,
    input  logic                  dmaWrite,
    input  logic [ADDR_WIDTH-1:0] dmaAddress,
    input  logic [63:0]           dmaWriteData,
    input  logic [1:0]            dmaSize,
    input  logic                  dmaSignExtended,
    output logic                  dmaGrant,
    output logic                  dmaValid,
    output logic [63:0]           dmaReadData,
    output logic                  dmaError,

    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [63:0]           memWriteData,
    output logic [1:0]            memSize,
    output logic                  memSignExtended,
    output logic                  memWriteEnable,
    input  logic [63:0]           memReadData,

    output logic                  busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [SW-1:0]         r_starve;
    logic                  r_selDma;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [63:0]           r_wdata;
    logic [1:0]            r_size;
    logic                  r_sext;
    logic [63:0]           r_coreReadData;
    logic [63:0]           r_dmaReadData;

    logic                  w_anyReq;
    logic                  w_starved;
    logic                  w_dmaWins;
    logic                  w_take;
    logic                  w_misaligned;
    logic [63:0]           w_loadData;

    assign w_anyReq  = coreReq | dmaReq;
    assign w_starved = (r_starve >= SW'(STARVE_LIMIT));
    assign w_dmaWins = dmaReq & (~coreReq | w_starved);
    assign w_take    = (r_state == ST_IDLE) & w_anyReq;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    dmem_align_check u_align (
        .i_size       (r_size),
        .i_addrLow    (r_addr[2:0]),
        .o_misaligned (w_misaligned)
    );
`else
    assign w_misaligned = 1'b0;
`endif

    // Stores and rejected accesses return zero on the response.
    assign w_loadData = (r_write | w_misaligned) ? 64'd0 : memReadData;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_anyReq) w_nextState = ST_ACCESS;
            ST_ACCESS: w_nextState = ST_RESP;
            ST_RESP:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        coreGrant       = 1'b0;
        dmaGrant        = 1'b0;
        coreValid       = 1'b0;
        dmaValid        = 1'b0;
        coreError       = 1'b0;
        dmaError        = 1'b0;
        memAddress      = '0;
        memWriteData    = '0;
        memSize         = '0;
        memSignExtended = 1'b0;
        memWriteEnable  = 1'b0;
        busy            = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                coreGrant = resetN & w_anyReq & ~w_dmaWins;
                dmaGrant  = resetN & w_dmaWins;
            end
            ST_ACCESS: begin
                busy            = 1'b1;
                memAddress      = r_addr;
                memWriteData    = r_wdata;
                memSize         = r_size;
                memSignExtended = r_sext;
                memWriteEnable  = r_write & ~w_misaligned;
            end
            ST_RESP: begin
                busy      = 1'b1;
                coreValid = ~r_selDma;
                dmaValid  = r_selDma;
                coreError = ~r_selDma & w_misaligned;
                dmaError  = r_selDma & w_misaligned;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_starve       <= '0;
            r_selDma       <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_size         <= '0;
            r_sext         <= 1'b0;
            r_coreReadData <= '0;
            r_dmaReadData  <= '0;
        end else begin
            if (w_take) begin
                r_selDma <= w_dmaWins;
                r_write  <= w_dmaWins ? dmaWrite : coreWrite;
                r_addr   <= w_dmaWins ? dmaAddress : coreAddress;
                r_wdata  <= w_dmaWins ? dmaWriteData : coreWriteData;
                r_size   <= w_dmaWins ? dmaSize : coreSize;
                r_sext   <= w_dmaWins ? dmaSignExtended : coreSignExtended;
                if (w_dmaWins) begin
                    r_starve <= '0;
                end else if (dmaReq && !w_starved) begin
                    r_starve <= r_starve + SW'(1);
                end
            end
            if (r_state == ST_ACCESS) begin
                if (r_selDma) begin
                    r_dmaReadData <= w_loadData;
                end else begin
                    r_coreReadData <= w_loadData;
                end
            end
        end
    end

    assign coreReadData = r_coreReadData;
    assign dmaReadData  = r_dmaReadData;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: grant order and responses
// are queued at stimulus time and checked when the DUT reports them.
module tb_data_memory_arbiter;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        logic        dma;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        coreReq, coreWrite, coreSignExtended;
    logic [10:0] coreAddress;
    logic [63:0] coreWriteData;
    logic [1:0]  coreSize;
    logic        coreGrant, coreValid, coreError;
    logic [63:0] coreReadData;
    logic        dmaReq, dmaWrite, dmaSignExtended;
    logic [10:0] dmaAddress;
    logic [63:0] dmaWriteData;
    logic [1:0]  dmaSize;
    logic        dmaGrant, dmaValid, dmaError;
    logic [63:0] dmaReadData;
    logic [10:0] memAddress;
    logic [63:0] memWriteData;
    logic [1:0]  memSize;
    logic        memSignExtended, memWriteEnable;
    logic [63:0] memReadData;
    logic        busy;

    int   nTests = 0;
    int   nFail  = 0;
    int   cyc    = 0;
    int   gcyc   = 0;
    int   weCnt  = 0;
    exp_t sbq[$];
    logic expGrant[$];

    data_memory_arbiter #(.ADDR_WIDTH(11), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetN(resetN),
        .coreReq(coreReq), .coreWrite(coreWrite),
        .coreAddress(coreAddress), .coreWriteData(coreWriteData),
        .coreSize(coreSize), .coreSignExtended(coreSignExtended),
        .coreGrant(coreGrant), .coreValid(coreValid),
        .coreReadData(coreReadData), .coreError(coreError),
        .dmaReq(dmaReq), .dmaWrite(dmaWrite),
        .dmaAddress(dmaAddress), .dmaWriteData(dmaWriteData),
        .dmaSize(dmaSize), .dmaSignExtended(dmaSignExtended),
        .dmaGrant(dmaGrant), .dmaValid(dmaValid),
        .dmaReadData(dmaReadData), .dmaError(dmaError),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memSize(memSize), .memSignExtended(memSignExtended),
        .memWriteEnable(memWriteEnable), .memReadData(memReadData),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            if (coreGrant || dmaGrant) begin
                gcyc = cyc;
                check("grant_onehot", 64'(coreGrant & dmaGrant), 64'd0);
                check("grant_pending", 64'(expGrant.size() != 0), 64'd1);
                if (expGrant.size() != 0)
                    check("grant_port", 64'(dmaGrant), 64'(expGrant.pop_front()));
            end
            if (memWriteEnable) weCnt++;
            if (coreValid || dmaValid) begin
                exp_t e;
                check("valid_onehot", 64'(coreValid & dmaValid), 64'd0);
                check("latency", 64'(cyc - gcyc), 64'd2);
                check("valid_pending", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("valid_port", 64'(dmaValid), 64'(e.dma));
                    check("rdata", e.dma ? dmaReadData : coreReadData, e.rdata);
                    check("error", 64'(e.dma ? dmaError : coreError), 64'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic dma, input logic wr,
                         input logic [10:0] addr, input logic [63:0] wd,
                         input logic [1:0] sz, input logic sx,
                         input logic expResp, input logic [63:0] rexp,
                         input logic eexp);
        exp_t e;
        e.dma = dma; e.rdata = rexp; e.err = eexp;
        expGrant.push_back(dma);
        if (expResp) sbq.push_back(e);
        if (dma) begin
            dmaReq = 1'b1; dmaWrite = wr; dmaAddress = addr;
            dmaWriteData = wd; dmaSize = sz; dmaSignExtended = sx;
        end else begin
            coreReq = 1'b1; coreWrite = wr; coreAddress = addr;
            coreWriteData = wd; coreSize = sz; coreSignExtended = sx;
        end
        @(posedge clk); #1;
        coreReq = 1'b0;
        dmaReq  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done", 64'(sbq.size() == 0 && !busy && expGrant.size() == 0), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   we0;
        exp_t e;
        resetN = 1'b0;
        coreReq = 1'b1; coreWrite = 1'b0; coreAddress = '0;
        coreWriteData = '0; coreSize = '0; coreSignExtended = 1'b0;
        dmaReq = 1'b1; dmaWrite = 1'b0; dmaAddress = '0;
        dmaWriteData = '0; dmaSize = '0; dmaSignExtended = 1'b0;
        memReadData = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_coreGrant", 64'(coreGrant), 64'd0);
        check("rst_dmaGrant", 64'(dmaGrant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(memWriteEnable), 64'd0);
        check("rst_memAddr", 64'(memAddress), 64'd0);
        check("rst_coreRd", coreReadData, 64'd0);
        check("rst_dmaRd", dmaReadData, 64'd0);
        check("rst_valid", 64'(coreValid | dmaValid), 64'd0);
        coreReq = 1'b0;
        dmaReq  = 1'b0;
        resetN  = 1'b1;
        @(posedge clk); #1;

        // Core double load
        we0 = weCnt;
        memReadData = 64'h1122334455667788;
        issue(1'b0, 1'b0, 11'h010, 64'd0, 2'b11, 1'b0,
              1'b1, 64'h1122334455667788, 1'b0);
        wait_done();
        check("t1_we", 64'(weCnt - we0), 64'd0);

        // DMA byte store
        we0 = weCnt;
        memReadData = 64'hDEADBEEFDEADBEEF;
        issue(1'b1, 1'b1, 11'h005, 64'hAB, 2'b00, 1'b0, 1'b1, 64'd0, 1'b0);
        check("t2_we_access", 64'(memWriteEnable), 64'd1);
        check("t2_addr", 64'(memAddress), 64'h005);
        check("t2_wdata", memWriteData, 64'hAB);
        wait_done();
        check("t2_we", 64'(weCnt - we0), 64'd1);
        check("t2_core_hold", coreReadData, 64'h1122334455667788);

        // Both requesting continuously: starvation relief
        memReadData = 64'h5555AAAA5555AAAA;
        for (int i = 0; i < 6; i++) begin
            e.dma = (i == 4); e.rdata = 64'h5555AAAA5555AAAA; e.err = 1'b0;
            expGrant.push_back(i == 4);
            sbq.push_back(e);
        end
        coreReq = 1'b1; coreWrite = 1'b0; coreAddress = 11'h020; coreSize = 2'b11;
        dmaReq = 1'b1; dmaWrite = 1'b0; dmaAddress = 11'h040; dmaSize = 2'b11;
        repeat (16) @(posedge clk);
        #1;
        coreReq = 1'b0;
        dmaReq  = 1'b0;
        wait_done();

        // Misaligned word store
        we0 = weCnt;
        issue(1'b0, 1'b1, 11'h006, 64'h12345678, 2'b10, 1'b0,
              1'b1, 64'd0, ALIGN_EN);
        wait_done();
        check("t4_we", 64'(weCnt - we0), ALIGN_EN ? 64'd0 : 64'd1);

        // Misaligned half load
        memReadData = 64'h000000000000CAFE;
        issue(1'b1, 1'b0, 11'h003, 64'd0, 2'b01, 1'b0,
              1'b1, ALIGN_EN ? 64'd0 : 64'hCAFE, ALIGN_EN);
        wait_done();

        // Aligned signed word load: mem fields during ACCESS
        memReadData = 64'hFFFFFFFF80000001;
        issue(1'b0, 1'b0, 11'h008, 64'd0, 2'b10, 1'b1,
              1'b1, 64'hFFFFFFFF80000001, 1'b0);
        check("t6_addr", 64'(memAddress), 64'h008);
        check("t6_size", 64'(memSize), 64'd2);
        check("t6_sext", 64'(memSignExtended), 64'd1);
        check("t6_we", 64'(memWriteEnable), 64'd0);
        wait_done();

        // Reset in the middle of a store access
        issue(1'b0, 1'b1, 11'h100, 64'h77, 2'b10, 1'b0, 1'b0, 64'd0, 1'b0);
        check("t7_we_pre", 64'(memWriteEnable), 64'd1);
        #2;
        resetN = 1'b0;
        #1;
        check("t7_we_async", 64'(memWriteEnable), 64'd0);
        check("t7_busy_rst", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        check("t7_busy_rel", 64'(busy), 64'd0);
        memReadData = 64'h0102030405060708;
        issue(1'b0, 1'b0, 11'h018, 64'd0, 2'b11, 1'b0,
              1'b1, 64'h0102030405060708, 1'b0);
        wait_done();
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
